// File: rtl/uart_command_receiver.sv
// 8N1 serial command receiver: validates 3'b101-headed bytes and presents the
// 5-bit index to the decoder as a stable number followed by a timed control pulse.
module uart_command_receiver #(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned HOLD_CYCLES = 5000000,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [4:0] number,
  output logic       control,
  output logic       frame_error,
  output logic       bad_cmd
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam int unsigned OMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned OW = $clog2(OMAX + 1);

  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [OW-1:0] HOLD_LAST = OW'(HOLD_CYCLES - 1);
  localparam logic [OW-1:0] GAP_LAST  = OW'(GAP_CYCLES - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  localparam logic [1:0] O_IDLE  = 2'd0;
  localparam logic [1:0] O_SETUP = 2'd1;
  localparam logic [1:0] O_HOLD  = 2'd2;
  localparam logic [1:0] O_GAP   = 2'd3;

  logic          r_rx_meta;
  logic          r_rx_sync;
  logic [2:0]    r_rstate;
  logic [BW-1:0] r_bit_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_byte_valid;
  logic          r_frame_error;

  logic [1:0]    r_ostate;
  logic [OW-1:0] r_ocnt;
  logic [4:0]    r_number;
  logic          r_control;
  logic [4:0]    r_pend;
  logic          r_pend_valid;
  logic          r_bad_cmd;

  logic          w_accept;
  logic          w_bad;
  logic [4:0]    w_cmd;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Receive path: mid-bit sampling, LSB-first shift into the MSB end.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rstate      <= S_IDLE;
      r_bit_cnt     <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_byte_valid  <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_byte_valid  <= 1'b0;
      r_frame_error <= 1'b0;
      case (r_rstate)
        S_IDLE: begin
          if (!r_rx_sync) begin
            r_rstate  <= S_START;
            r_bit_cnt <= '0;
          end
        end
        S_START: begin
          if (r_bit_cnt == HALF_LAST) begin
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_rstate  <= r_rx_sync ? S_IDLE : S_DATA;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_bit_cnt == BIT_LAST) begin
            r_bit_cnt <= '0;
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) r_rstate <= S_STOP;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_bit_cnt == BIT_LAST) begin
            r_bit_cnt <= '0;
            if (r_rx_sync) begin
              r_byte_valid <= 1'b1;
              r_rstate     <= S_IDLE;
            end else begin
              r_frame_error <= 1'b1;
              r_rstate      <= S_WAIT_HIGH;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (r_rx_sync) r_rstate <= S_IDLE;
        end
        default: r_rstate <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_cmd    = r_shift[4:0];
    w_accept = r_byte_valid && (r_shift[7:5] == 3'b101);
    w_bad    = r_byte_valid && (r_shift[7:5] != 3'b101);
  end

  // Output path; a command arriving while busy parks in the single pending slot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ostate     <= O_IDLE;
      r_ocnt       <= '0;
      r_number     <= '0;
      r_control    <= 1'b0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_bad_cmd    <= 1'b0;
    end else begin
      r_bad_cmd <= w_bad;
      case (r_ostate)
        O_IDLE: begin
          if (w_accept) begin
            r_number     <= w_cmd;
            r_pend_valid <= 1'b0;
            r_ostate     <= O_SETUP;
          end else if (r_pend_valid) begin
            r_number     <= r_pend;
            r_pend_valid <= 1'b0;
            r_ostate     <= O_SETUP;
          end
        end
        O_SETUP: begin
          r_ocnt    <= '0;
          r_control <= 1'b1;
          r_ostate  <= O_HOLD;
        end
        O_HOLD: begin
          if (r_ocnt == HOLD_LAST) begin
            r_ocnt    <= '0;
            r_control <= 1'b0;
            r_ostate  <= O_GAP;
          end else begin
            r_ocnt <= r_ocnt + 1'b1;
          end
        end
        O_GAP: begin
          if (r_ocnt == GAP_LAST) begin
            r_ocnt   <= '0;
            r_ostate <= O_IDLE;
          end else begin
            r_ocnt <= r_ocnt + 1'b1;
          end
        end
        default: r_ostate <= O_IDLE;
      endcase
      if (w_accept && (r_ostate != O_IDLE)) begin
        r_pend       <= w_cmd;
        r_pend_valid <= 1'b1;
      end
    end
  end

  assign number      = r_number;
  assign control     = r_control;
  assign frame_error = r_frame_error;
  assign bad_cmd     = r_bad_cmd;

endmodule

// File: tb/tb_uart_command_receiver.sv
// Scoreboard bench: dut1 uses the short hold; dut2 uses a long hold so
// back-to-back bytes land in the pending slot and exercise overwrite.
module tb_uart_command_receiver;

  localparam int BIT  = 16;
  localparam int HOLD = 8;
  localparam int HOLD2 = 400;
  localparam int GAP  = 2;
  localparam int EV_NONE = 0;
  localparam int EV_CMD  = 1;
  localparam int EV_BAD  = 2;
  localparam int EV_FE   = 3;

  typedef struct {
    int kind;
    int num;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       r_rx;
  logic       en2;
  logic       rx2;
  logic [4:0] number1, number2;
  logic       control1, control2;
  logic       frame_error1, frame_error2;
  logic       bad_cmd1, bad_cmd2;
  logic       mon_en;

  int n_checks = 0;
  int n_errors = 0;
  ev_t q1[$];
  ev_t q2[$];

  assign rx2 = en2 ? r_rx : 1'b1;

  uart_command_receiver #(
    .CLK_HZ(1600000), .BAUD(100000), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)
  ) dut1 (
    .clock(clk), .reset(rst), .rx(r_rx), .number(number1),
    .control(control1), .frame_error(frame_error1), .bad_cmd(bad_cmd1)
  );

  uart_command_receiver #(
    .CLK_HZ(1600000), .BAUD(100000), .HOLD_CYCLES(HOLD2), .GAP_CYCLES(GAP)
  ) dut2 (
    .clock(clk), .reset(rst), .rx(rx2), .number(number2),
    .control(control2), .frame_error(frame_error2), .bad_cmd(bad_cmd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push1(input int kind, input int num);
    ev_t e;
    e.kind = kind;
    e.num  = num;
    q1.push_back(e);
  endtask

  task automatic push2(input int num);
    ev_t e;
    e.kind = EV_CMD;
    e.num  = num;
    q2.push_back(e);
  endtask

  task automatic take1(input int kind, input int num);
    ev_t e;
    if (q1.size() == 0) begin
      check_val("sb1_unexpected", kind, EV_NONE);
    end else begin
      e = q1.pop_front();
      check_val("sb1_kind", kind, e.kind);
      if (e.kind == EV_CMD) check_val("sb1_number", num, e.num);
    end
  endtask

  // dut1 monitor
  int       hold1, low1;
  logic     prev_ctrl1;
  logic [4:0] prev_num1, hold_num1;
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      prev_ctrl1 = 1'b0;
      hold1      = 0;
      low1       = 1000;
      prev_num1  = number1;
    end else begin
      if (bad_cmd1) take1(EV_BAD, 0);
      if (frame_error1) take1(EV_FE, 0);
      if (control1 && !prev_ctrl1) begin
        take1(EV_CMD, number1);
        check_val("num_setup", prev_num1, number1);
        check_val("gap_low", low1 >= GAP, 1);
        hold1     = 1;
        hold_num1 = number1;
      end else if (control1) begin
        hold1++;
        if (number1 !== hold_num1) check_val("num_stable", number1, hold_num1);
      end
      if (!control1 && prev_ctrl1) begin
        check_val("hold_len", hold1, HOLD);
        low1 = 0;
      end
      if (!control1) low1++;
      prev_ctrl1 = control1;
      prev_num1  = number1;
    end
  end

  // dut2 monitor
  int   hold2, low2;
  logic prev_ctrl2;
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      prev_ctrl2 = 1'b0;
      hold2      = 0;
      low2       = 1000;
    end else begin
      if (bad_cmd2 || frame_error2) check_val("dut2_err", {bad_cmd2, frame_error2}, 0);
      if (control2 && !prev_ctrl2) begin
        if (q2.size() == 0) begin
          check_val("sb2_unexpected", number2, 32'hFFFF);
        end else begin
          ev_t e;
          e = q2.pop_front();
          check_val("sb2_number", number2, e.num);
        end
        check_val("gap2_low", low2 >= GAP, 1);
        hold2 = 1;
      end else if (control2) begin
        hold2++;
      end
      if (!control2 && prev_ctrl2) begin
        check_val("hold2_len", hold2, HOLD2);
        low2 = 0;
      end
      if (!control2) low2++;
      prev_ctrl2 = control2;
    end
  end

  task automatic drive_bit(input logic v);
    r_rx = v;
    repeat (BIT) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q1.size() == 0 && q2.size() == 0 && !control1 && !control2) break;
      @(posedge clk);
    end
    repeat (20) @(posedge clk);
    check_val("drain_q1", q1.size(), 0);
    check_val("drain_q2", q2.size(), 0);
  endtask

  initial begin
    rst    = 1'b1;
    r_rx   = 1'b1;
    en2    = 1'b0;
    mon_en = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_val("rst_number", number1, 0);
    check_val("rst_control", control1, 0);
    check_val("rst_fe", frame_error1, 0);
    check_val("rst_bad", bad_cmd1, 0);
    check_val("rst_number2", number2, 0);
    mon_en = 1'b1;
    repeat (500) @(posedge clk);
    #1;
    check_val("idle_number", number1, 0);
    check_val("idle_control", control1, 0);

    push1(EV_CMD, 5);
    send_byte(8'hA5, 1'b1);
    r_rx = 1'b1;
    drain(200);
    check_val("a5_number_hold", number1, 5);

    push1(EV_BAD, 0);
    send_byte(8'h45, 1'b1);
    r_rx = 1'b1;
    drain(200);
    check_val("bad_num_keep", number1, 5);

    push1(EV_FE, 0);
    send_byte(8'hA4, 1'b0);
    r_rx = 1'b0;
    repeat (100) @(posedge clk);
    r_rx = 1'b1;
    repeat (32) @(posedge clk);
    push1(EV_CMD, 3);
    send_byte(8'hA3, 1'b1);
    r_rx = 1'b1;
    drain(200);
    check_val("fe_number", number1, 3);

    en2 = 1'b1;
    push1(EV_CMD, 1);
    push1(EV_CMD, 2);
    push1(EV_CMD, 3);
    push2(1);
    push2(3);
    send_byte(8'hA1, 1'b1);
    send_byte(8'hA2, 1'b1);
    send_byte(8'hA3, 1'b1);
    r_rx = 1'b1;
    drain(3000);
    en2 = 1'b0;
    check_val("b2b_number2", number2, 3);

    r_rx = 1'b0;
    repeat (4) @(posedge clk);
    r_rx = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    check_val("glitch_control", control1, 0);
    check_val("glitch_number", number1, 3);

    push1(EV_CMD, 5);
    send_byte(8'hA5, 1'b1);
    r_rx = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (control1) break;
      @(posedge clk);
      #1;
    end
    check_val("rise_wait", control1, 1);
    repeat (3) @(posedge clk);
    mon_en = 1'b0;
    #3 rst = 1'b1;
    #1;
    check_val("midhold_control", control1, 0);
    check_val("midhold_number", number1, 0);
    check_val("midhold_fe", frame_error1, 0);
    check_val("midhold_bad", bad_cmd1, 0);
    check_val("midhold_q1", q1.size(), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check_val("post_rst_control", control1, 0);
    check_val("post_rst_number", number1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
